// File: rtl/rf_writeback_queue.sv
// rtl/rf_writeback_queue.sv - in-order write-back queue feeding the register-file write port
// Merges ALU and load results, commits one per cycle and forwards pending values to decode.
module rf_writeback_queue #(
  parameter int DW    = 8,
  parameter int AW    = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     ld_valid,
  output logic                     ld_ready,
  input  logic [AW-1:0]            ld_rd,
  input  logic [DW-1:0]            ld_data,
  output logic                     rf_wen,
  output logic [AW-1:0]            rf_rd,
  output logic [DW-1:0]            rf_din,
  input  logic [AW-1:0]            fwd_rs1,
  input  logic [AW-1:0]            fwd_rs2,
  output logic                     fwd1_hit,
  output logic                     fwd2_hit,
  output logic [DW-1:0]            fwd1_data,
  output logic [DW-1:0]            fwd2_data,
  output logic [$clog2(DEPTH):0]   pending_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] r_rd_q   [DEPTH];
  logic [DW-1:0] r_data_q [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_cnt;
  logic          r_wen;
  logic [AW-1:0] r_rd;
  logic [DW-1:0] r_din;

  logic          w_pop;
  logic [CW:0]   w_avail;
  logic [CW:0]   w_ld_need;
  logic          w_alu_acc;
  logic          w_ld_acc;
  logic          w_enq0_v;
  logic [AW-1:0] w_enq0_rd;
  logic [DW-1:0] w_enq0_data;
  logic          w_enq1_v;
  logic [PW-1:0] w_tail1;
  logic [PW-1:0] w_tail_next;
  logic [CW-1:0] w_cnt_next;

  assign w_pop     = (r_cnt != '0);
  assign w_avail   = (CW+1)'(DEPTH) - {1'b0, r_cnt} + {{CW{1'b0}}, w_pop};
  assign alu_ready = (w_avail != '0);
  assign w_alu_acc = alu_valid & alu_ready;
  // A same-cycle ALU acceptance consumes one slot before the load is considered.
  assign w_ld_need = w_alu_acc ? (CW+1)'(2) : (CW+1)'(1);
  assign ld_ready  = (w_avail >= w_ld_need);
  assign w_ld_acc  = ld_valid & ld_ready;

  // Results not taken by the bypass path are appended ALU first, then load.
  always_comb begin
    w_enq0_v    = 1'b0;
    w_enq0_rd   = alu_rd;
    w_enq0_data = alu_data;
    w_enq1_v    = 1'b0;
    if (w_pop) begin
      if (w_alu_acc) begin
        w_enq0_v = 1'b1;
        w_enq1_v = w_ld_acc;
      end else if (w_ld_acc) begin
        w_enq0_v    = 1'b1;
        w_enq0_rd   = ld_rd;
        w_enq0_data = ld_data;
      end
    end else if (w_alu_acc && w_ld_acc) begin
      w_enq0_v    = 1'b1;
      w_enq0_rd   = ld_rd;
      w_enq0_data = ld_data;
    end
  end

  assign w_tail1     = r_tail + 1'b1;
  assign w_tail_next = r_tail + PW'(w_enq0_v) + PW'(w_enq1_v);
  assign w_cnt_next  = r_cnt + CW'(w_enq0_v) + CW'(w_enq1_v) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd_q[i]   <= '0;
        r_data_q[i] <= '0;
      end
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= '0;
      r_wen  <= 1'b0;
      r_rd   <= '0;
      r_din  <= '0;
    end else begin
      if (w_pop) begin
        r_wen  <= 1'b1;
        r_rd   <= r_rd_q[r_head];
        r_din  <= r_data_q[r_head];
        r_head <= r_head + 1'b1;
      end else if (w_alu_acc) begin
        r_wen <= 1'b1;
        r_rd  <= alu_rd;
        r_din <= alu_data;
      end else if (w_ld_acc) begin
        r_wen <= 1'b1;
        r_rd  <= ld_rd;
        r_din <= ld_data;
      end else begin
        r_wen <= 1'b0;
      end
      if (w_enq0_v) begin
        r_rd_q[r_tail]   <= w_enq0_rd;
        r_data_q[r_tail] <= w_enq0_data;
      end
      if (w_enq1_v) begin
        r_rd_q[w_tail1]   <= ld_rd;
        r_data_q[w_tail1] <= ld_data;
      end
      r_tail <= w_tail_next;
      r_cnt  <= w_cnt_next;
    end
  end

  // Port stage is the oldest candidate; queue entries scanned oldest to youngest so the youngest match wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx       = r_head;
    fwd1_hit  = r_wen && (r_rd == fwd_rs1);
    fwd1_data = fwd1_hit ? r_din : '0;
    fwd2_hit  = r_wen && (r_rd == fwd_rs2);
    fwd2_data = fwd2_hit ? r_din : '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_head + PW'(i);
      if ((CW'(i) < r_cnt) && (r_rd_q[idx] == fwd_rs1)) begin
        fwd1_hit  = 1'b1;
        fwd1_data = r_data_q[idx];
      end
      if ((CW'(i) < r_cnt) && (r_rd_q[idx] == fwd_rs2)) begin
        fwd2_hit  = 1'b1;
        fwd2_data = r_data_q[idx];
      end
    end
  end

  assign rf_wen      = r_wen;
  assign rf_rd       = r_rd;
  assign rf_din      = r_din;
  assign pending_cnt = r_cnt;

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side front end for the 8x8 register file. It merges results from the single-cycle ALU and the multi-cycle load unit.
- It buffers the results in an in-order pending-write queue and drives the register file's single write port (wen/rd/din), one write per cycle.
- It provides forwarding for two read addresses, so decode sees results that are still queued or not yet committed.

Parameters:
- DW, 8, data width; matches register width.
- AW, 3, register address width (8 registers).
- DEPTH, 4, pending-write queue entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU result present this cycle.
- alu_ready  out  1  queue can take the ALU result; upstream stalls when low.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  DW  ALU result.
- ld_valid  in  1  load result present.
- ld_ready  out  1  load result accepted this cycle.
- ld_rd  in  AW  load destination register.
- ld_data  in  DW  load data.
- rf_wen  out  1  register-file write enable (registered).
- rf_rd  out  AW  register-file write address (registered).
- rf_din  out  DW  register-file write data (registered).
- fwd_rs1, fwd_rs2  in  AW  decode read addresses.
- fwd1_hit, fwd2_hit  out  1  newer value pending for rs1/rs2.
- fwd1_data, fwd2_data  out  DW  forwarded value; 0 when no hit.
- pending_cnt  out  $clog2(DEPTH)+1  queued entries (excludes the write-port stage).

Behaviour:
- Reset, async on rst_n low:
  - Queue emptied; pointers = 0; pending_cnt = 0.
  - rf_wen = 0, rf_rd = 0, rf_din = 0.
  - Reset mid-operation discards all queued and in-flight writes; nothing is committed.
- Definitions:
  - cnt = queue occupancy.
  - pop = (cnt != 0).
  - avail = DEPTH - cnt + pop.
- Handshake:
  - alu_ready = (avail >= 1).
  - ld_ready = (avail >= 1 + (alu_valid & alu_ready)).
  - A source is accepted when valid & ready. Data must be held stable while valid & !ready.
- Per rising edge, write-port selection in priority order:
  - (a) If pop: head entry goes to rf_*, rf_wen = 1, head is removed.
  - (b) Else if ALU accepted: ALU result goes directly to rf_* (bypass, not enqueued).
  - (c) Else if load accepted: load result goes directly to rf_*.
  - (d) Else rf_wen = 0; rf_rd/rf_din hold their previous values.
- Enqueue: accepted results not consumed by (b)/(c) are appended in order: ALU first, then load, in the same cycle.
- Ordering: commits occur strictly in acceptance order; same-cycle ALU precedes load.
- Latency: an accepted result with an empty queue appears on rf_* the next cycle; the register file commits one edge later.
- Simultaneous enqueue+pop is legal. cnt_next = cnt + enq_count - pop, and never exceeds DEPTH.
- Pointers wrap modulo DEPTH.
- Full boundary:
  - cnt = DEPTH gives avail = 1: only one new result is accepted; ALU wins.
  - ld_ready = 0 whenever an ALU result is accepted in that cycle.
- Forwarding (combinational) for each rsN. Search order, youngest first:
  - Queue entries, tail down to head.
  - Then the write-port stage, if rf_wen = 1.
  - First match gives hit = 1 and data = that entry.
  - No match gives hit = 0, data = 0.
  - Inputs being accepted in the current cycle are not forwarded.
- No register is special: writes to r0 commit like any other.

Test Plan:
- Reset: assert rst_n = 0 mid-burst with 3 queued -> rf_wen = 0, pending_cnt = 0 immediately; after release no stale write occurs.
- Bypass: empty queue, alu_valid with rd = 2, data = 0x5A -> next cycle rf_wen = 1, rf_rd = 2, rf_din = 0x5A; pending_cnt = 0.
- Same-cycle collision: empty queue, ALU (rd = 1, 0x11) and load (rd = 1, 0x22) together -> cycle+1 writes 0x11, cycle+2 writes 0x22; fwd_rs1 = 1 at cycle+1 gives hit = 1, data = 0x22.
- Fill to full: ALU every cycle plus load every cycle from empty -> pending_cnt saturates at 4; with cnt = 4, alu_ready = 1 and ld_ready = 0 while ALU valid; no entry lost; 8 writes drain in acceptance order.
- Forwarding priority: queue holds rd = 3 with values 0x01 then 0x02, and the port stage has rd = 3 with 0x00 -> fwd hit data = 0x02; after drain, hit = 0 and data = 0.
- Wrap-around: 10 enqueue/pop cycles interleaved with stalls -> pointers wrap and commit sequence matches a reference FIFO model exactly.
